// File: rtl/asrv32_clint.sv
// Machine timer / software-interrupt controller: owns mtime, mtimecmp and msip,
// serves them on the data bus and mirrors mtime/mtimecmp updates to the CSR unit.
module asrv32_clint #(
    parameter int unsigned CLK_FREQ_MHZ = 100,
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_sel,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_timer_interrupt,
    output logic        o_software_interrupt,
    output logic        o_mtime_wr_en,
    output logic [63:0] o_mtime_dout,
    output logic        o_mtimecmp_wr_en,
    output logic [63:0] o_mtimecmp_dout
);

    localparam int unsigned CNT_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ_MHZ - 1);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_MSIP     = 3'd4;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             msip_q, msip_d;
    logic             ack_q, ack_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             mtime_we_q, mtime_we_d;
    logic             mtimecmp_we_q, mtimecmp_we_d;
    logic             tirq_q, tirq_d;

    logic             sel_c;
    logic             wr_c;
    logic             rd_c;
    logic             tick_c;
    logic [2:0]       off_c;
    logic [31:0]      rmux_c;
    logic             unused_c;

    assign unused_c = ^i_addr[1:0];

    // Byte-lane merge of write data into an existing 32-bit word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_comb begin
        cnt_d         = cnt_q;
        mtime_d       = mtime_q;
        mtimecmp_d    = mtimecmp_q;
        msip_d        = msip_q;
        ack_d         = 1'b0;
        rdata_d       = 32'd0;
        mtime_we_d    = 1'b0;
        mtimecmp_we_d = 1'b0;
        tirq_d        = 1'b0;
        rmux_c        = 32'd0;

        sel_c  = i_stb && (i_addr[31:5] == BASE_ADDR[31:5]);
        wr_c   = sel_c && i_we && (i_sel != 4'd0);
        rd_c   = sel_c && !i_we;
        off_c  = i_addr[4:2];
        tick_c = (cnt_q == CNT_MAX);

        cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);

        if (tick_c) begin
            mtime_d    = mtime_q + 64'd1;
            mtime_we_d = 1'b1;
        end

        // Bus writes override the tick; the untouched half holds, no carry.
        if (wr_c) begin
            case (off_c)
                OFF_MTIME_LO: begin
                    mtime_d    = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wdata, i_sel)};
                    mtime_we_d = 1'b1;
                end
                OFF_MTIME_HI: begin
                    mtime_d    = {merge_bytes(mtime_q[63:32], i_wdata, i_sel), mtime_q[31:0]};
                    mtime_we_d = 1'b1;
                end
                OFF_CMP_LO: begin
                    mtimecmp_d    = {mtimecmp_q[63:32], merge_bytes(mtimecmp_q[31:0], i_wdata, i_sel)};
                    mtimecmp_we_d = 1'b1;
                end
                OFF_CMP_HI: begin
                    mtimecmp_d    = {merge_bytes(mtimecmp_q[63:32], i_wdata, i_sel), mtimecmp_q[31:0]};
                    mtimecmp_we_d = 1'b1;
                end
                OFF_MSIP: begin
                    if (i_sel[0]) begin
                        msip_d = i_wdata[0];
                    end
                end
                default: ;
            endcase
        end

        case (off_c)
            OFF_MTIME_LO: rmux_c = mtime_q[31:0];
            OFF_MTIME_HI: rmux_c = mtime_q[63:32];
            OFF_CMP_LO:   rmux_c = mtimecmp_q[31:0];
            OFF_CMP_HI:   rmux_c = mtimecmp_q[63:32];
            OFF_MSIP:     rmux_c = {31'd0, msip_q};
            default:      rmux_c = 32'd0;
        endcase

        ack_d   = sel_c;
        rdata_d = rd_c ? rmux_c : 32'd0;
        tirq_d  = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q         <= '0;
            mtime_q       <= 64'd0;
            mtimecmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q        <= 1'b0;
            ack_q         <= 1'b0;
            rdata_q       <= 32'd0;
            mtime_we_q    <= 1'b0;
            mtimecmp_we_q <= 1'b0;
            tirq_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            mtime_q       <= mtime_d;
            mtimecmp_q    <= mtimecmp_d;
            msip_q        <= msip_d;
            ack_q         <= ack_d;
            rdata_q       <= rdata_d;
            mtime_we_q    <= mtime_we_d;
            mtimecmp_we_q <= mtimecmp_we_d;
            tirq_q        <= tirq_d;
        end
    end

    assign o_ack                = ack_q;
    assign o_rdata              = rdata_q;
    assign o_timer_interrupt    = tirq_q;
    assign o_software_interrupt = msip_q;
    assign o_mtime_wr_en        = mtime_we_q;
    assign o_mtime_dout         = mtime_q;
    assign o_mtimecmp_wr_en     = mtimecmp_we_q;
    assign o_mtimecmp_dout      = mtimecmp_q;

endmodule

// File: tb/tb_asrv32_clint.sv
// Directed bench for asrv32_clint at a 4 MHz prescale: reset, prescaler,
// compare interrupt, byte enables, write/tick collision and decode edges.
module tb_asrv32_clint;

    logic        clk;
    logic        rst_n;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        tirq;
    logic        sirq;
    logic        mtime_we;
    logic [63:0] mtime;
    logic        cmp_we;
    logic [63:0] cmp;

    int checks = 0;
    int errors = 0;
    int pulses;

    asrv32_clint #(
        .CLK_FREQ_MHZ(4),
        .BASE_ADDR   (32'h8000_0000)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_stb               (stb),
        .i_we                (we),
        .i_addr              (addr),
        .i_sel               (sel),
        .i_wdata             (wdata),
        .o_ack               (ack),
        .o_rdata             (rdata),
        .o_timer_interrupt   (tirq),
        .o_software_interrupt(sirq),
        .o_mtime_wr_en       (mtime_we),
        .o_mtime_dout        (mtime),
        .o_mtimecmp_wr_en    (cmp_we),
        .o_mtimecmp_dout     (cmp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stb   = 1'b0;
        we    = 1'b0;
        addr  = 32'd0;
        sel   = 4'd0;
        wdata = 32'd0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two reset cycles, then release; the next posedge is edge 1.
    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // One request, consumed by the next posedge; outputs sampled on the negedge after.
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        stb   = 1'b1;
        we    = w;
        addr  = a;
        sel   = s;
        wdata = d;
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // Reset values
        step(2);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_mtime", mtime, 64'd0);
        chk("rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_mtime_we", 64'(mtime_we), 64'd0);
        chk("rst_cmp_we", 64'(cmp_we), 64'd0);
        chk("rst_tirq", 64'(tirq), 64'd0);
        chk("rst_sirq", 64'(sirq), 64'd0);
        rst_n = 1'b1;
        bus(1'b0, 32'h8000_0008, 4'h0, 32'd0);
        chk("rst_rd08_ack", 64'(ack), 64'd1);
        chk("rst_rd08", 64'(rdata), 64'hFFFF_FFFF);
        bus(1'b0, 32'h8000_000C, 4'h0, 32'd0);
        chk("rst_rd0c", 64'(rdata), 64'hFFFF_FFFF);
        step(1);
        chk("idle_rdata", 64'(rdata), 64'd0);

        // Prescaler
        do_reset();
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (mtime_we) pulses++;
        end
        chk("pre_mtime4", mtime, 64'd1);
        chk("pre_pulses4", 64'(pulses), 64'd1);
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            step(1);
            if (mtime_we) pulses++;
        end
        chk("pre_mtime40", mtime, 64'd10);
        chk("pre_pulses40", 64'(pulses), 64'd9);

        // Timer compare
        do_reset();
        bus(1'b1, 32'h8000_0008, 4'hF, 32'd5);
        chk("cmp_lo_we", 64'(cmp_we), 64'd1);
        chk("cmp_lo", cmp, 64'hFFFF_FFFF_0000_0005);
        bus(1'b1, 32'h8000_000C, 4'hF, 32'd0);
        chk("cmp_hi_we", 64'(cmp_we), 64'd1);
        chk("cmp_hi", cmp, 64'd5);
        step(18);
        chk("cmp_mtime5", mtime, 64'd5);
        chk("cmp_tirq_lag", 64'(tirq), 64'd0);
        chk("cmp_we_idle", 64'(cmp_we), 64'd0);
        step(1);
        chk("cmp_tirq_rise", 64'(tirq), 64'd1);
        bus(1'b1, 32'h8000_0008, 4'hF, 32'hFFFF_FFFF);
        chk("cmp_raise", cmp, 64'h0000_0000_FFFF_FFFF);
        chk("cmp_tirq_hold", 64'(tirq), 64'd1);
        step(1);
        chk("cmp_tirq_drop", 64'(tirq), 64'd0);
        bus(1'b1, 32'h8000_000C, 4'hF, 32'd0);
        chk("cmp_same_we", 64'(cmp_we), 64'd1);
        chk("cmp_same", cmp, 64'h0000_0000_FFFF_FFFF);

        // Byte enables and msip
        do_reset();
        bus(1'b1, 32'h8000_0010, 4'b0001, 32'hFFFF_FFFF);
        chk("msip_sirq", 64'(sirq), 64'd1);
        bus(1'b0, 32'h8000_0010, 4'h0, 32'd0);
        chk("msip_rd", 64'(rdata), 64'd1);
        bus(1'b1, 32'h8000_0000, 4'hF, 32'h1122_3344);
        chk("be_full", mtime, 64'h0000_0000_1122_3344);
        bus(1'b1, 32'h8000_0000, 4'b0010, 32'h0000_AB00);
        chk("be_byte1_tick", mtime, 64'h0000_0000_1122_AB44);
        chk("be_byte1_we", 64'(mtime_we), 64'd1);
        bus(1'b1, 32'h8000_0004, 4'b1000, 32'hCD00_0000);
        chk("be_hi_byte3", mtime, 64'hCD00_0000_1122_AB44);
        bus(1'b1, 32'h8000_0000, 4'b0000, 32'hFFFF_FFFF);
        chk("be_sel0_ack", 64'(ack), 64'd1);
        chk("be_sel0_mtime", mtime, 64'hCD00_0000_1122_AB44);
        chk("be_sel0_we", 64'(mtime_we), 64'd0);
        bus(1'b0, 32'h8000_0004, 4'h0, 32'd0);
        chk("be_rd_hi", 64'(rdata), 64'hCD00_0000);
        step(1);
        chk("be_tick", mtime, 64'hCD00_0000_1122_AB45);

        // Write-vs-tick collision
        do_reset();
        step(3);
        bus(1'b1, 32'h8000_0000, 4'hF, 32'h0000_0100);
        chk("col_wins", mtime, 64'h100);
        bus(1'b1, 32'h8000_0000, 4'hF, 32'hFFFF_FFFF);
        step(2);
        chk("col_pre_wrap", mtime, 64'h0000_0000_FFFF_FFFF);
        step(1);
        chk("col_carry", mtime, 64'h0000_0001_0000_0000);
        step(3);
        bus(1'b0, 32'h8000_0000, 4'h0, 32'd0);
        chk("col_rd_old", 64'(rdata), 64'd0);
        chk("col_rd_tick", mtime, 64'h0000_0001_0000_0001);
        bus(1'b0, 32'h8000_0004, 4'h0, 32'd0);
        chk("col_rd_hi", 64'(rdata), 64'd1);

        // Decode boundaries
        do_reset();
        bus(1'b0, 32'h8000_0018, 4'h0, 32'd0);
        chk("dec_rsv_ack", 64'(ack), 64'd1);
        chk("dec_rsv_rd", 64'(rdata), 64'd0);
        bus(1'b1, 32'h8000_0020, 4'hF, 32'hFFFF_FFFF);
        chk("dec_out_ack", 64'(ack), 64'd0);
        bus(1'b1, 32'h8000_0014, 4'hF, 32'hFFFF_FFFF);
        chk("dec_rsv_wr_ack", 64'(ack), 64'd1);
        chk("dec_mtime", mtime, 64'd0);
        chk("dec_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
        stb   = 1'b1;
        we    = 1'b0;
        addr  = 32'h8000_0000;
        rst_n = 1'b0;
        @(negedge clk);
        idle();
        chk("dec_rst_ack", 64'(ack), 64'd0);
        rst_n = 1'b1;
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/asrv32_clint.md
# asrv32_clint

Memory-mapped machine timer and software-interrupt controller for the ASRV32 core. It sits on the data bus and owns the 64-bit `mtime`/`mtimecmp` registers and the `msip` bit. It drives the machine timer and software interrupt lines into the CSR/trap unit, and mirrors `mtime`/`mtimecmp` updates to it through write-enable/data pairs. It is the producer side of the CSR unit's timer/interrupt inputs.

## Interface
- `CLK_FREQ_MHZ`, 100: core clock in MHz; `mtime` advances once per microsecond. Must be ≥1.
- `BASE_ADDR`, 32'h8000_0000: 32-byte-aligned base of the register window.
- `i_clk`  in  1  core clock.
- `i_rst_n`  in  1  reset; one clock; synchronous, active-low.
- `i_stb`  in  1  bus request valid (one cycle per request).
- `i_we`  in  1  1 = write, 0 = read.
- `i_addr`  in  32  byte address; bits [1:0] ignored.
- `i_sel`  in  4  byte enables for writes.
- `i_wdata`  in  32  write data.
- `o_ack`  out  1  request completed; one-cycle pulse.
- `o_rdata`  out  32  read data; valid while `o_ack`=1, 0 otherwise.
- `o_timer_interrupt`  out  1  level: `mtime` ≥ `mtimecmp`.
- `o_software_interrupt`  out  1  level: `msip`.
- `o_mtime_wr_en`  out  1  pulse: `o_mtime_dout` changed this cycle.
- `o_mtime_dout`  out  64  current `mtime`.
- `o_mtimecmp_wr_en`  out  1  pulse: `o_mtimecmp_dout` changed this cycle.
- `o_mtimecmp_dout`  out  64  current `mtimecmp`.

## Operation
- **Window decode**
  - A request is selected when `i_stb`=1 and `i_addr[31:5]`==`BASE_ADDR[31:5]`.
  - Unselected requests are ignored: no ack, no state change.
- **Register map** (word offsets)
  - 0x00 `mtime`[31:0]
  - 0x04 `mtime`[63:32]
  - 0x08 `mtimecmp`[31:0]
  - 0x0C `mtimecmp`[63:32]
  - 0x10 `msip` (bit 0 only; bits 31:1 read 0, ignore writes)
  - 0x14–0x1C reserved: read 0, writes ignored, still acked.
- **Writes**
  - Byte-granular per `i_sel`; unselected bytes are unchanged.
  - `i_sel`=0 still acks and changes nothing.
- **Prescaler**
  - Counter runs 0..`CLK_FREQ_MHZ`-1; `tick` is asserted the cycle it equals `CLK_FREQ_MHZ`-1, then it wraps to 0.
  - With `CLK_FREQ_MHZ`=1, `tick` is asserted every cycle.
  - A bus write never resets the prescaler.
- **mtime update priority**
  - A bus write to either `mtime` half wins over `tick` in the same cycle; that tick's increment is lost.
  - The other half holds; there is no carry.
  - Otherwise `tick` increments `mtime` by 1, wrapping modulo 2^64.
- **Mirror outputs**
  - `o_mtime_wr_en` is registered alongside `mtime` and is 1 in exactly the cycles where `o_mtime_dout` shows a new value (tick or bus write).
  - `o_mtimecmp_wr_en` is 1 in the cycle `o_mtimecmp_dout` shows a bus-written value, including when the written value is unchanged.
- **Timer interrupt**
  - `o_timer_interrupt` is a registered unsigned 64-bit compare of the current `mtime` and `mtimecmp` register values.
  - It stays high until software raises `mtimecmp` or lowers `mtime`.
- **Read data**
  - Captured from register values before any same-cycle update (tick or write).

## Timing
- **Reset values** (all outputs/registers): `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, prescaler=0, `o_ack`=0, `o_rdata`=0, both `wr_en`=0, both interrupts=0.
- **Reset mid-operation:** an ack pending from the previous cycle is dropped.
- **Bus latency**
  - Request in cycle N → `o_ack`=1 in cycle N+1, with `o_rdata` valid for reads.
  - A write's register effect is visible in cycle N+1.
  - Back-to-back requests every cycle are supported; there is no stall.
- **Tick latency:** `tick` in cycle N → `o_mtime_dout` incremented and `o_mtime_wr_en`=1 in cycle N+1.
- **Interrupt latency:** `o_timer_interrupt` lags the `mtime`/`mtimecmp` register values by exactly one cycle.
- **Software interrupt:** `o_software_interrupt` equals the `msip` register and is visible in cycle N+1 after a write in cycle N.
- **64-bit reads:** not atomic; software re-reads the high word around the low word.

## Test plan
- **Reset:** assert `i_rst_n`=0 for 2 cycles → all outputs at reset values; read of 0x08/0x0C returns 0xFFFF_FFFF each.
- **Prescaler** (`CLK_FREQ_MHZ`=4): after release, 4 cycles → `o_mtime_dout`=1 with a single `o_mtime_wr_en` pulse; 40 cycles → 10.
- **Timer compare:** write 0x08=5, then 0x0C=0 → `o_mtimecmp_wr_en` pulses; `o_timer_interrupt` rises the cycle after `mtime` reaches 5. Write 0x08=0xFFFF_FFFF → it drops one cycle after the register update.
- **Byte enables and msip:**
  - write 0x10 with `i_wdata`=0xFFFF_FFFF, `i_sel`=4'b0001 → `o_software_interrupt`=1; read 0x10 returns 0x0000_0001.
  - write 0x00 with `i_sel`=4'b0010, `i_wdata`=0x0000_AB00 → only `mtime`[15:8]=0xAB changes.
- **Write-vs-tick collision:** write 0x00=0x100 in a tick cycle → `mtime`=0x100 next cycle, not 0x101; write 0x00=0xFFFF_FFFF → the next tick gives `mtime`=0x1_0000_0000.
- **Decode boundaries:**
  - read 0x18 → ack with 0.
  - request at `BASE_ADDR`+0x20 → no ack.
  - reset asserted in the cycle after a request → `o_ack`=0.
